// File: rtl/ccg_bist_controller.sv
// BIST controller: LFSR/exhaustive pattern source, MISR response compactor
// and golden-signature compare for combinational netlists under test.
module ccg_bist_controller #(
  parameter int unsigned          N_IN          = 5,
  parameter int unsigned          N_OUT         = 10,
  parameter int unsigned          PATTERN_COUNT = 32,
  parameter logic [N_IN-1:0]      LFSR_TAPS     = 5'b00101,
  parameter logic [N_IN-1:0]      LFSR_SEED     = {{(N_IN-1){1'b0}}, 1'b1},
  parameter logic [N_OUT-1:0]     MISR_TAPS     = 10'b0000001001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [N_OUT-1:0] golden,
  output logic [N_IN-1:0]  pat_out,
  input  logic [N_OUT-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature,
  output logic [15:0]      pat_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N_IN-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? {{(N_IN-1){1'b0}}, 1'b1} : LFSR_SEED;
  localparam logic [15:0] LAST_CNT = 16'(PATTERN_COUNT - 1);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [N_IN-1:0]  pat_q, pat_d, pat_step;
  logic [N_OUT-1:0] sig_q, sig_d, sig_step;
  logic [15:0]      cnt_q, cnt_d;
  logic             pass_q, pass_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      pat_q   <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    sig_step = {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? MISR_TAPS : '0) ^ resp_in;
    pat_step = mode_q ? pat_q + 1'b1
                      : {pat_q[N_IN-2:0], 1'b0} ^ (pat_q[N_IN-1] ? LFSR_TAPS : '0);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          pat_d   = mode ? '0 : SEED_EFF;
          sig_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        // The abort edge still absorbs its response; values freeze from then on.
        sig_d = sig_step;
        cnt_d = cnt_q + 16'd1;
        pat_d = pat_step;
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          pass_d  = (sig_step == golden);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pat_out   = pat_q;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;
  assign pass      = pass_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_ccg_bist_controller.sv
// Bench for ccg_bist_controller: polynomial-level model compared every cycle,
// plus hand-computed literal checks on a 32-pattern and a 2-pattern instance.
module tb_ccg_bist_controller;

  localparam int unsigned PC = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [9:0]  golden = '0, resp_in;
  logic [4:0]  pat_out;
  logic        busy, done, pass;
  logic [9:0]  signature;
  logic [15:0] pat_cnt;

  logic        start2 = 1'b0, abort2 = 1'b0, mode2 = 1'b1;
  logic [9:0]  golden2 = '0, resp_in2 = 10'h001;
  logic [4:0]  pat_out2;
  logic        busy2, done2, pass2;
  logic [9:0]  signature2;
  logic [15:0] pat_cnt2;

  int variant = 2;
  bit flip_en = 1'b0;

  int unsigned total = 0, passed = 0;

  ccg_bist_controller #(
    .N_IN(5), .N_OUT(10), .PATTERN_COUNT(PC),
    .LFSR_TAPS(5'b00101), .LFSR_SEED(5'd1), .MISR_TAPS(10'b0000001001)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .golden(golden), .pat_out(pat_out), .resp_in(resp_in), .busy(busy),
    .done(done), .pass(pass), .signature(signature), .pat_cnt(pat_cnt)
  );

  ccg_bist_controller #(.PATTERN_COUNT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .mode(mode2),
    .golden(golden2), .pat_out(pat_out2), .resp_in(resp_in2), .busy(busy2),
    .done(done2), .pass(pass2), .signature(signature2), .pat_cnt(pat_cnt2)
  );

  // Two structurally different forms of the same benchmark function; 2 = tied low.
  function automatic logic [9:0] netlist(input logic [4:0] p, input int v);
    logic [9:0] r;
    case (v)
      0: r = {p + 5'd3, p[4] & p[0], p[3] | p[1], ~p[2],
              (p[0] & p[1]) | (p[2] & p[3]), (p[0] ^ p[1]) ^ (p[2] ^ p[3]) ^ p[4]};
      1: r = {(p + 5'd1) + 5'd2, p[0] & p[4], p[1] | p[3], ~p[2],
              (p[2] & p[3]) | (p[0] & p[1]), (((p[0] ^ p[1]) ^ p[2]) ^ p[3]) ^ p[4]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb
    resp_in = netlist(pat_out, variant) ^ ((flip_en && pat_cnt == 16'd7) ? 10'h010 : 10'h000);

  // GF(2) polynomial multiply-by-x, modulo x^5+x^2+1 and x^10+x^3+1.
  function automatic logic [4:0] mulx5(input logic [4:0] s);
    return {s[3:0], 1'b0} ^ (s[4] ? 5'h05 : 5'h00);
  endfunction
  function automatic logic [9:0] mulx10(input logic [9:0] s);
    return {s[8:0], 1'b0} ^ (s[9] ? 10'h009 : 10'h000);
  endfunction

  function automatic logic [4:0] pat_at(input bit md, input int unsigned k);
    logic [4:0] s;
    if (md) return 5'(k % 32);
    s = 5'h01;
    for (int unsigned i = 0; i < k; i++) s = mulx5(s);
    return s;
  endfunction

  function automatic logic [9:0] sig_of(input logic [9:0] q[$]);
    logic [9:0] s;
    s = '0;
    foreach (q[i]) s = mulx10(s) ^ q[i];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: a run is a list of absorbed responses plus a pattern index.
  bit          m_run = 0, m_done = 0, m_pass = 0, m_mode = 0, m_fresh = 1;
  int unsigned m_k = 0;
  logic [9:0]  m_resp[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_done <= 0; m_pass <= 0; m_k <= 0; m_fresh <= 1;
      m_resp.delete();
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1; m_done <= 0; m_pass <= 0; m_k <= 0; m_mode <= mode; m_fresh <= 0;
        m_resp.delete();
      end
    end else begin
      m_resp.push_back(resp_in);
      m_k <= m_k + 1;
      if (abort) begin
        m_run <= 0; m_pass <= 0;
      end else if (m_k + 1 == PC) begin
        m_run <= 0; m_done <= 1;
        m_pass <= (sig_of(m_resp) == golden);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pass", pass, m_pass);
      chk("pat_cnt", pat_cnt, m_k);
      chk("pat_out", pat_out, m_fresh ? 5'h00 : pat_at(m_mode, m_k));
      chk("signature", signature, sig_of(m_resp));
    end
  end

  task automatic do_start(input bit md);
    @(negedge clk); mode = md; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  logic [9:0] exp_sig;
  logic [4:0] lfsr_exp[9];
  int n, busy_cycles;

  initial begin
    lfsr_exp = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h05, 5'h0A, 5'h14, 5'h0D};
    begin
      logic [9:0] q[$];
      for (int k = 0; k < 32; k++) q.push_back(netlist(5'(k), 0));
      exp_sig = sig_of(q);
    end

    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_pat_out", pat_out, 0); chk("rst_signature", signature, 0);
    chk("rst_pat_cnt", pat_cnt, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);       chk("rst_pass", pass, 0);

    // Exhaustive, responses tied low.
    variant = 2; golden = '0;
    do_start(1'b1);
    chk("exh_first_pat", pat_out, 5'd0);
    n = 0; busy_cycles = 1;
    while (!done && n < 200) begin
      @(negedge clk); n++;
      if (busy) busy_cycles++;
      if (n == 31) chk("exh_pat31", pat_out, 5'd31);
    end
    chk("exh_done_latency", n, 32);
    chk("exh_busy_cycles", busy_cycles, 32);
    chk("exh_sig_zero", signature, 10'h000);
    chk("exh_pass", pass, 1'b1);

    // Two-pattern instance with constant response.
    for (int g = 0; g < 2; g++) begin
      golden2 = (g == 0) ? 10'h003 : 10'h002;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      chk("p2_sig_e0", signature2, 10'h000);
      @(negedge clk);
      chk("p2_sig_e1", signature2, 10'h001); chk("p2_done_e1", done2, 1'b0);
      @(negedge clk);
      chk("p2_sig_e2", signature2, 10'h003); chk("p2_done_e2", done2, 1'b1);
      chk("p2_pass", pass2, (g == 0) ? 1'b1 : 1'b0);
    end
    // Abort on the completing edge wins.
    golden2 = 10'h003;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    @(negedge clk); abort2 = 1'b1;
    @(negedge clk); abort2 = 1'b0;
    chk("p2_abort_done", done2, 1'b0); chk("p2_abort_busy", busy2, 1'b0);
    chk("p2_abort_cnt", pat_cnt2, 16'd2); chk("p2_abort_pass", pass2, 1'b0);

    // LFSR sequence from the default seed.
    variant = 0; golden = '0;
    do_start(1'b0);
    for (int k = 0; k < 32; k++) begin
      if (k < 9) chk("lfsr_seq", pat_out, lfsr_exp[k]);
      if (k < 31) chk("lfsr_nonzero", pat_out != 5'h00, 1'b1);
      if (k == 31) chk("lfsr_period", pat_out, 5'h01);
      if (k < 31) @(negedge clk);
    end
    wait_done("lfsr", n);

    // Equivalence of netlist variants, then a single injected bit flip.
    golden = exp_sig;
    for (int v = 0; v < 3; v++) begin
      variant = (v == 0) ? 0 : 1;
      flip_en = (v == 2);
      do_start(1'b1);
      wait_done("equiv", n);
      chk("equiv_sig", signature == exp_sig, (v == 2) ? 1'b0 : 1'b1);
      chk("equiv_pass", pass, (v == 2) ? 1'b0 : 1'b1);
    end
    flip_en = 1'b0; variant = 0;

    // Start ignored while running; abort at pat_cnt 5.
    do_start(1'b0);
    n = 0;
    while (pat_cnt != 16'd3 && n < 50) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (pat_cnt != 16'd5 && n < 50) begin @(negedge clk); n++; end
    chk("abort_reach5", pat_cnt, 16'd5);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0); chk("abort_done", done, 1'b0);
    chk("abort_pass", pass, 1'b0); chk("abort_cnt", pat_cnt, 16'd6);
    @(negedge clk); abort = 1'b0;
    chk("abort_idle_hold", pat_cnt, 16'd6);

    // Asynchronous reset mid-run, then a clean rerun.
    do_start(1'b1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pat_out", pat_out, 0); chk("arst_signature", signature, 0);
    chk("arst_pat_cnt", pat_cnt, 0); chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);       chk("arst_pass", pass, 0);
    @(negedge clk); #2 rst = 1'b0;
    do_start(1'b1);
    wait_done("rerun", n);
    chk("rerun_sig", signature, exp_sig);
    chk("rerun_pass", pass, 1'b1);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
